// File: rtl/hack_ps2_kbd.sv
// PS/2 keyboard receiver for the HACK PC: pad conditioning, 11-bit frame capture,
// make/break/extended tracking and scan-code set 2 to HACK key-code translation.
module hack_ps2_kbd #(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic        clk1,
   input  logic        rst,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [15:0] key,
   output logic        key_we,
   output logic        frame_err
);

   localparam int FCW = $clog2(FILTER_LEN + 1);
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } state_e;

   // Input conditioning
   logic [1:0]     sync_clk_q, sync_clk_d;
   logic [1:0]     sync_data_q, sync_data_d;
   logic [FCW-1:0] filt_cnt_q, filt_cnt_d;
   logic           fclk_q, fclk_d;
   logic           clk_s, data_s, fall;

   // Frame receiver
   state_e         state_q, state_d;
   logic [7:0]     shift_q, shift_d;
   logic [2:0]     bit_cnt_q, bit_cnt_d;
   logic           parity_q, parity_d;
   logic [TCW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic           tmo_hit;
   logic           rx_vld_q, rx_vld_d;
   logic           rx_err_q, rx_err_d;

   // Decoder
   logic           ext_q, ext_d;
   logic           brk_q, brk_d;
   logic [15:0]    key_q, key_d;
   logic           key_we_q, key_we_d;
   logic           frame_err_q, frame_err_d;
   logic [15:0]    code;

   function automatic logic [15:0] xlate(input logic [8:0] sc);
      logic [15:0] v;
      v = 16'd0;
      case (sc)
         9'h01C: v = 16'd65;   9'h032: v = 16'd66;   9'h021: v = 16'd67;
         9'h023: v = 16'd68;   9'h024: v = 16'd69;   9'h02B: v = 16'd70;
         9'h034: v = 16'd71;   9'h033: v = 16'd72;   9'h043: v = 16'd73;
         9'h03B: v = 16'd74;   9'h042: v = 16'd75;   9'h04B: v = 16'd76;
         9'h03A: v = 16'd77;   9'h031: v = 16'd78;   9'h044: v = 16'd79;
         9'h04D: v = 16'd80;   9'h015: v = 16'd81;   9'h02D: v = 16'd82;
         9'h01B: v = 16'd83;   9'h02C: v = 16'd84;   9'h03C: v = 16'd85;
         9'h02A: v = 16'd86;   9'h01D: v = 16'd87;   9'h022: v = 16'd88;
         9'h035: v = 16'd89;   9'h01A: v = 16'd90;
         9'h045: v = 16'd48;   9'h016: v = 16'd49;   9'h01E: v = 16'd50;
         9'h026: v = 16'd51;   9'h025: v = 16'd52;   9'h02E: v = 16'd53;
         9'h036: v = 16'd54;   9'h03D: v = 16'd55;   9'h03E: v = 16'd56;
         9'h046: v = 16'd57;
         9'h029: v = 16'd32;   9'h05A: v = 16'd128;  9'h066: v = 16'd129;
         9'h076: v = 16'd140;
         9'h16B: v = 16'd130;  9'h175: v = 16'd131;  9'h174: v = 16'd132;
         9'h172: v = 16'd133;  9'h16C: v = 16'd134;  9'h169: v = 16'd135;
         9'h171: v = 16'd139;
         default: v = 16'd0;
      endcase
      return v;
   endfunction

   assign clk_s  = sync_clk_q[1];
   assign data_s = sync_data_q[1];

   // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      sync_clk_d  = {sync_clk_q[0], ps2_clk};
      sync_data_d = {sync_data_q[0], ps2_data};
      filt_cnt_d  = filt_cnt_q;
      fclk_d      = fclk_q;
      if (clk_s == fclk_q) begin
         filt_cnt_d = '0;
      end else if (filt_cnt_q == FCW'(FILTER_LEN - 1)) begin
         fclk_d     = clk_s;
         filt_cnt_d = '0;
      end else begin
         filt_cnt_d = filt_cnt_q + FCW'(1);
      end
   end

   // Falling edge is seen in the cycle the filtered level is about to drop.
   assign fall    = fclk_q & ~fclk_d;
   assign tmo_hit = (state_q != IDLE) && !fall && (tmo_cnt_q == TCW'(TIMEOUT_CYCLES - 1));

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (fall && !data_s)             state_d = DATA;
         DATA:    if (fall && bit_cnt_q == 3'd7)   state_d = PARITY;
         PARITY:  if (fall)                        state_d = STOP;
         STOP:    if (fall)                        state_d = IDLE;
         default:                                  state_d = IDLE;
      endcase
      if (tmo_hit) state_d = IDLE;
   end

   // Frame outputs: byte-valid and error strobes toward the decoder
   always_comb begin
      rx_vld_d = 1'b0;
      rx_err_d = 1'b0;
      case (state_q)
         IDLE: if (fall && data_s) rx_err_d = 1'b1;
         STOP: begin
            if (fall) begin
               if (data_s && (^{shift_q, parity_q})) rx_vld_d = 1'b1;
               else                                  rx_err_d = 1'b1;
            end
         end
         default: ;
      endcase
      if (tmo_hit) rx_err_d = 1'b1;
   end

   // Receiver datapath
   always_comb begin
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      parity_d  = parity_q;
      tmo_cnt_d = (state_q == IDLE || fall || tmo_hit) ? '0 : tmo_cnt_q + TCW'(1);
      if (fall) begin
         case (state_q)
            IDLE:    bit_cnt_d = 3'd0;
            DATA: begin
               shift_d   = {data_s, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
            end
            PARITY:  parity_d = data_s;
            default: ;
         endcase
      end
   end

   // Decoder: shift_q holds the delivered byte while rx_vld_q is high.
   assign code = xlate({ext_q, shift_q});

   always_comb begin
      ext_d       = ext_q;
      brk_d       = brk_q;
      key_d       = key_q;
      key_we_d    = 1'b0;
      frame_err_d = rx_err_q;
      if (rx_vld_q) begin
         if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
         end else if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
         end else begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (code != 16'd0) begin
               if (!brk_q && code != key_q) begin
                  key_d    = code;
                  key_we_d = 1'b1;
               end else if (brk_q && code == key_q) begin
                  key_d    = 16'd0;
                  key_we_d = 1'b1;
               end
            end
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk1) begin
      if (rst) begin
         sync_clk_q  <= 2'b11;
         sync_data_q <= 2'b11;
         filt_cnt_q  <= '0;
         fclk_q      <= 1'b1;
         state_q     <= IDLE;
         shift_q     <= 8'd0;
         bit_cnt_q   <= 3'd0;
         parity_q    <= 1'b0;
         tmo_cnt_q   <= '0;
         rx_vld_q    <= 1'b0;
         rx_err_q    <= 1'b0;
         ext_q       <= 1'b0;
         brk_q       <= 1'b0;
         key_q       <= 16'd0;
         key_we_q    <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         sync_clk_q  <= sync_clk_d;
         sync_data_q <= sync_data_d;
         filt_cnt_q  <= filt_cnt_d;
         fclk_q      <= fclk_d;
         state_q     <= state_d;
         shift_q     <= shift_d;
         bit_cnt_q   <= bit_cnt_d;
         parity_q    <= parity_d;
         tmo_cnt_q   <= tmo_cnt_d;
         rx_vld_q    <= rx_vld_d;
         rx_err_q    <= rx_err_d;
         ext_q       <= ext_d;
         brk_q       <= brk_d;
         key_q       <= key_d;
         key_we_q    <= key_we_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign key       = key_q;
   assign key_we    = key_we_q;
   assign frame_err = frame_err_q;

endmodule
